// File: rtl/enet_mdio_pkg.sv
// Shared constants, state type and frame-tail builder for the Clause-22 MDIO master.
package enet_mdio_pkg;

  localparam logic [1:0] ST_BITS  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] TA_WRITE = 2'b10;

  localparam int PRE_LEN    = 32;
  localparam int FRAME_BITS = 64;

  localparam logic [5:0] SLOT_HDR  = 6'd32;
  localparam logic [5:0] SLOT_TA   = 6'd46;
  localparam logic [5:0] SLOT_DATA = 6'd48;
  localparam logic [5:0] SLOT_LAST = 6'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA,
    S_DONE
  } state_t;

  // Bits sent after the preamble; read frames carry 1s where the net is released.
  function automatic logic [31:0] build_tail(input logic        write,
                                             input logic [4:0]  phy_addr,
                                             input logic [4:0]  reg_addr,
                                             input logic [15:0] wdata);
    if (write)
      return {ST_BITS, OP_WRITE, phy_addr, reg_addr, TA_WRITE, wdata};
    else
      return {ST_BITS, OP_READ, phy_addr, reg_addr, 2'b11, 16'hFFFF};
  endfunction

endpackage

// File: rtl/enet_mdio_clk_div.sv
// MDC generator: CLK_DIV cycles per half period, held low and reset while restart is high.
module enet_mdio_clk_div #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic mdc,
  output logic fall_tick,
  output logic sample_tick,
  output logic slot_end
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          high_half;
  logic          half_end;

  assign half_end    = !restart && (cnt == HALF_LAST);
  assign sample_tick = half_end && !high_half;
  assign fall_tick   = half_end && high_half;
  assign slot_end    = half_end && high_half;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      high_half <= 1'b0;
      mdc       <= 1'b0;
    end else if (restart) begin
      cnt       <= '0;
      high_half <= 1'b0;
      mdc       <= 1'b0;
    end else if (half_end) begin
      cnt       <= '0;
      high_half <= !high_half;
      mdc       <= !high_half;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/enet_mdio_master.sv
// Clause-22 MDIO master: serializes one 64-slot management frame per accepted command.
module enet_mdio_master
  import enet_mdio_pkg::*;
#(
  parameter int CLK_DIV = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oen,
  input  logic        mdio_in
);

  state_t      state;
  logic [5:0]  slot;
  logic [5:0]  slot_next;
  logic [31:0] tx_sr;
  logic [15:0] rx_sr;
  logic        is_write;
  logic        ta_err;
  logic        accept;
  logic        restart;
  logic        fall_tick;
  logic        sample_tick;
  logic        slot_end;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign restart   = (state == S_IDLE) || (state == S_DONE);
  assign slot_next = slot + 6'd1;

  enet_mdio_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk        (clk),
    .reset      (reset),
    .restart    (restart),
    .mdc        (mdc),
    .fall_tick  (fall_tick),
    .sample_tick(sample_tick),
    .slot_end   (slot_end)
  );

  // Response registers load at the end of slot 63 so rsp_valid is high during DONE itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      slot      <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      is_write  <= 1'b0;
      ta_err    <= 1'b0;
      mdio_out  <= 1'b1;
      mdio_oen  <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state    <= S_PRE;
            slot     <= '0;
            is_write <= cmd_write;
            tx_sr    <= build_tail(cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata);
            rx_sr    <= '0;
            ta_err   <= 1'b0;
            mdio_out <= 1'b1;
            mdio_oen <= 1'b0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          if (sample_tick && !is_write) begin
            if (slot == SLOT_TA + 6'd1) ta_err <= mdio_in;
            if (slot >= SLOT_DATA) rx_sr <= {rx_sr[14:0], mdio_in};
          end
          if (fall_tick && (slot != SLOT_LAST)) begin
            if (slot_next < 6'(PRE_LEN)) begin
              mdio_out <= 1'b1;
            end else begin
              mdio_out <= tx_sr[31];
              tx_sr    <= {tx_sr[30:0], 1'b0};
            end
            mdio_oen <= !is_write && (slot_next >= SLOT_TA);
          end
          if (slot_end) begin
            if (slot == SLOT_LAST) begin
              state     <= S_DONE;
              mdio_out  <= 1'b1;
              mdio_oen  <= 1'b1;
              rsp_valid <= 1'b1;
              rsp_rdata <= is_write ? 16'h0000 : rx_sr;
              rsp_err   <= !is_write && ta_err;
            end else begin
              slot <= slot_next;
              if (slot_next == SLOT_HDR)       state <= S_HDR;
              else if (slot_next == SLOT_TA)   state <= S_TA;
              else if (slot_next == SLOT_DATA) state <= S_DATA;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enet_mdio_master.sv
// Directed plus randomized bench for enet_mdio_master with a bit-level PHY model
// and a frame-layout reference model.
module tb_enet_mdio_master;

  localparam int CLK_DIV = 2;
  localparam int FRAME_CYC = 128 * CLK_DIV;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_phy_addr;
  logic [4:0]  cmd_reg_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        mdc;
  logic        mdio_out;
  logic        mdio_oen;
  logic        mdio_in;
  logic        phy_bit;

  int tests;
  int fails;
  int last_wait;

  logic        next_write;
  logic [4:0]  next_phy;
  logic [4:0]  next_reg;
  logic [15:0] next_wdata;

  // Shared net: the master's driver wins unless it releases, then the PHY (or pull-up) shows.
  assign mdio_in = mdio_oen ? phy_bit : mdio_out;

  enet_mdio_master #(
    .CLK_DIV(CLK_DIV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_phy_addr(cmd_phy_addr),
    .cmd_reg_addr(cmd_reg_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .mdc         (mdc),
    .mdio_out    (mdio_out),
    .mdio_oen    (mdio_oen),
    .mdio_in     (mdio_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_frame(input logic wr, input logic [4:0] phy,
                                              input logic [4:0] rg, input logic [15:0] wd);
    return {32'hFFFF_FFFF, 2'b01, (wr ? 2'b01 : 2'b10), phy, rg, 2'b10, wd};
  endfunction

  // Called at a negedge; returns at the negedge of the cycle after rsp_valid.
  task automatic run_frame(input string tag, input logic wr, input logic [4:0] phy,
                           input logic [4:0] rg, input logic [15:0] wd, input bit present,
                           input logic [15:0] pdata, input bit hold_next);
    logic [63:0] got_frame, got_oen, exp_frame, exp_oen, mask;
    logic [15:0] exp_rdata;
    logic        exp_err;
    logic        prev_mdc;
    int          rises, waited, lat;
    waited = 0;
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk($sformatf("%s/ready", tag), cmd_ready, 1);
    last_wait    = waited;
    cmd_valid    = 1;
    cmd_write    = wr;
    cmd_phy_addr = phy;
    cmd_reg_addr = rg;
    cmd_wdata    = wd;
    @(negedge clk);
    if (hold_next) begin
      cmd_write    = next_write;
      cmd_phy_addr = next_phy;
      cmd_reg_addr = next_reg;
      cmd_wdata    = next_wdata;
    end else begin
      cmd_valid = 0;
    end
    rises = 0;
    prev_mdc = 0;
    lat = 0;
    got_frame = '0;
    got_oen = '0;
    for (int c = 1; c <= FRAME_CYC + 20 && lat == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (mdc && !prev_mdc) begin
        if (rises < 64) begin
          got_frame[63-rises] = mdio_out;
          got_oen[63-rises]   = mdio_oen;
        end
        rises++;
      end
      prev_mdc = mdc;
      if (present && rises == 47) phy_bit = 1'b0;
      else if (present && rises >= 48 && rises < 64) phy_bit = pdata[63-rises];
      else phy_bit = 1'b1;
      if (c == 8) begin
        chk($sformatf("%s/busy", tag), busy, 1);
        chk($sformatf("%s/no_ready_busy", tag), cmd_ready, 0);
      end
      if (rsp_valid) lat = c;
    end
    phy_bit = 1'b1;
    exp_frame = model_frame(wr, phy, rg, wd);
    mask      = wr ? 64'hFFFF_FFFF_FFFF_FFFF : ~64'h3_FFFF;
    exp_oen   = wr ? 64'h0 : 64'h3_FFFF;
    exp_rdata = wr ? 16'h0000 : (present ? pdata : 16'hFFFF);
    exp_err   = !wr && !present;
    chk($sformatf("%s/latency", tag), lat, 1 + FRAME_CYC);
    chk($sformatf("%s/mdc_rises", tag), rises, 64);
    chk($sformatf("%s/mdc_low_done", tag), mdc, 0);
    chk($sformatf("%s/frame", tag), got_frame & mask, exp_frame & mask);
    chk($sformatf("%s/oen", tag), got_oen, exp_oen);
    chk($sformatf("%s/rdata", tag), rsp_rdata, exp_rdata);
    chk($sformatf("%s/err", tag), rsp_err, exp_err);
    @(negedge clk);
    chk($sformatf("%s/pulse", tag), rsp_valid, 0);
    chk($sformatf("%s/ready_after", tag), cmd_ready, 1);
    chk($sformatf("%s/rdata_hold", tag), rsp_rdata, exp_rdata);
    chk($sformatf("%s/mdc_idle", tag), mdc, 0);
  endtask

  initial begin
    int          seen;
    logic        r_wr;
    logic [4:0]  r_phy, r_reg;
    logic [15:0] r_wd, r_pd;
    bit          r_present;
    tests = 0;
    fails = 0;
    last_wait = 0;
    clk = 0;
    reset = 1;
    cmd_valid = 0;
    cmd_write = 0;
    cmd_phy_addr = '0;
    cmd_reg_addr = '0;
    cmd_wdata = '0;
    phy_bit = 1'b1;
    next_write = 0;
    next_phy = '0;
    next_reg = '0;
    next_wdata = '0;

    repeat (3) @(negedge clk);
    chk("rst/mdc", mdc, 0);
    chk("rst/mdio_out", mdio_out, 1);
    chk("rst/mdio_oen", mdio_oen, 1);
    chk("rst/rsp_valid", rsp_valid, 0);
    chk("rst/rsp_rdata", rsp_rdata, 0);
    chk("rst/rsp_err", rsp_err, 0);
    chk("rst/busy", busy, 0);
    reset = 0;
    @(negedge clk);
    chk("rst/cmd_ready", cmd_ready, 1);

    run_frame("wr1140", 1'b1, 5'h10, 5'h00, 16'h1140, 1'b0, 16'h0000, 1'b0);
    run_frame("rd0141", 1'b0, 5'h01, 5'h02, 16'h0000, 1'b1, 16'h0141, 1'b0);
    run_frame("rd_nophy", 1'b0, 5'h01, 5'h02, 16'h0000, 1'b0, 16'h0000, 1'b0);

    // First frame keeps cmd_valid high with different fields; its bits must be unaffected.
    next_write = 1'b0;
    next_phy   = 5'h03;
    next_reg   = 5'h04;
    next_wdata = 16'h0000;
    run_frame("b2b_first", 1'b1, 5'h1F, 5'h1A, 16'hA5C3, 1'b0, 16'h0000, 1'b1);
    run_frame("b2b_second", 1'b0, 5'h03, 5'h04, 16'h0000, 1'b1, 16'h7E81, 1'b0);
    chk("b2b/accept_next_cycle", last_wait, 0);

    cmd_valid    = 1;
    cmd_write    = 1;
    cmd_phy_addr = 5'h05;
    cmd_reg_addr = 5'h09;
    cmd_wdata    = 16'hBEEF;
    @(negedge clk);
    cmd_valid = 0;
    repeat (40 * 2 * CLK_DIV + CLK_DIV) @(negedge clk);
    chk("abort/mdc_high_before", mdc, 1);
    reset = 1;
    #1;
    chk("abort/mdc", mdc, 0);
    chk("abort/oen", mdio_oen, 1);
    chk("abort/out", mdio_out, 1);
    chk("abort/busy", busy, 0);
    repeat (3) @(negedge clk);
    reset = 0;
    seen = 0;
    for (int i = 0; i < FRAME_CYC + 40; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("abort/no_rsp", seen, 0);
    run_frame("abort/read_after", 1'b0, 5'h0A, 5'h11, 16'h0000, 1'b1, 16'h3C5A, 1'b0);

    for (int k = 0; k < 5; k++) begin
      r_wr      = 1'($urandom_range(0, 1));
      r_phy     = 5'($urandom);
      r_reg     = 5'($urandom);
      r_wd      = 16'($urandom);
      r_pd      = 16'($urandom);
      r_present = ($urandom_range(0, 3) != 0);
      run_frame($sformatf("rand%0d", k), r_wr, r_phy, r_reg, r_wd, r_present, r_pd, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/enet_mdio_master.md
# enet_mdio_master

Clause-22 MDIO management master for the Ethernet PHYs. It takes one register read or write command at a time from the Nios-side register interface and serializes the 64-bit management frame. It generates MDC and drives the shared `mdc`, `mdio_out` and `mdio_oen` nets that the top level fans out to ENET0 and ENET1. It returns read data, and an error flag when no PHY answers.

## Interface
Parameters:
- `CLK_DIV`, default 10: number of `clk` cycles per MDC half-period. The MDC period is 2×CLK_DIV cycles, which gives 2.5 MHz at 50 MHz. Legal range is ≥2.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge. One clock; reset is asynchronous and active-high.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  block is idle and accepts a command this cycle.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_phy_addr`  in  5  PHY address.
- `cmd_reg_addr`  in  5  register address.
- `cmd_wdata`  in  16  write data.
- `rsp_valid`  out  1  one-cycle pulse when a frame completes.
- `rsp_rdata`  out  16  read data; 0 for writes.
- `rsp_err`  out  1  read turnaround error (PHY did not drive TA bit 1 low).
- `busy`  out  1  a frame is in progress.
- `mdc`  out  1  management clock.
- `mdio_out`  out  1  serial data out.
- `mdio_oen`  out  1  1 = release the MDIO net (tri-state), 0 = drive `mdio_out`.
- `mdio_in`  in  1  sampled MDIO net.

## Operation
- **Frame layout**, slots 0..63, sent MSB first:
  - Slots 0–31: preamble, all 1s.
  - Slots 32–33: ST = 01.
  - Slots 34–35: OP = 01 for a write, 10 for a read.
  - Slots 36–40: PHYAD.
  - Slots 41–45: REGAD.
  - Slots 46–47: TA. A write drives 10. A read releases the net.
  - Slots 48–63: DATA.
- **States:** IDLE → PRE → HDR → TA → DATA → DONE → IDLE.
  - PRE covers 32 slots. HDR covers 14 slots. TA covers 2 slots. DATA covers 16 slots.
  - DONE lasts exactly one `clk` cycle and pulses `rsp_valid`.
- **Handshake:**
  - A command is accepted on any cycle with `cmd_valid & cmd_ready`. All command fields are latched on that cycle.
  - `cmd_ready` = (state == IDLE).
  - `busy` = !IDLE.
  - A `cmd_valid` asserted while busy is not accepted. The requester holds it.
- **Drive rules:**
  - Write frames: `mdio_oen` = 0 for all 64 slots.
  - Read frames: `mdio_oen` = 0 for slots 0–45 and 1 for slots 46–63.
  - Outside frames: `mdio_oen` = 1 and `mdio_out` = 1.
- **Read capture:**
  - `mdio_in` is sampled in slot 47 (TA bit 1). If the sample is 1, `rsp_err` = 1.
  - Slots 48–63 are shifted into the data register MSB first.
  - Data is captured regardless of the error flag. With a floating/pulled-up bus, the result is 0xFFFF with err = 1.
- **Response outputs:**
  - `rsp_rdata` and `rsp_err` update in DONE and hold until the next DONE.
  - For writes, they load 0.
- **Reset values:** `mdc` 0, `mdio_out` 1, `mdio_oen` 1, `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0, `busy` 0. `cmd_ready` is 1 after reset deasserts.
- **Reset mid-frame:** the frame is aborted immediately (async). The net is released, and no `rsp_valid` is produced.

## Timing
- **Slot structure:** each slot is 2×CLK_DIV `clk` cycles.
  - First half: MDC low.
  - Second half: MDC high.
- **Output update:** `mdio_out` and `mdio_oen` update on the first cycle of each slot, coincident with the MDC falling edge. The PHY therefore sees CLK_DIV cycles of setup and hold.
- **Sampling:** `mdio_in` is sampled on the last cycle of the low half of a slot, immediately before MDC rises.
- **Latency:** a command accepted at cycle t starts slot 0 at t+1. `rsp_valid` = 1 at cycle t+1+128×CLK_DIV.
- **Back-to-back commands:** `cmd_ready` = 1 in the cycle after DONE. A command accepted then starts its slot 0 one cycle later.
- **MDC idle:** MDC stays low whenever the block is IDLE. There are no MDC pulses between frames.
- **Counters:**
  - Divider: ⌈log2(CLK_DIV)⌉ bits. It resets to 0 at every slot-half boundary and on command accept.
  - Slot counter: 6 bits, counting 0..63 without wrap. The terminal count moves the FSM to DONE.

## Structure
- **Package `enet_mdio_pkg`:**
  - `ST_BITS` = 2'b01.
  - `OP_WRITE` = 2'b01, `OP_READ` = 2'b10.
  - `TA_WRITE` = 2'b10.
  - `PRE_LEN` = 32, `FRAME_BITS` = 64.
  - Slot boundary constants: 32, 46, 48.
  - State enum type.
- **Sub-module `enet_mdio_clk_div`:**
  - Inputs: `clk`, `reset`, and a synchronous `restart`.
  - Outputs: `mdc` plus single-cycle `fall_tick`, `sample_tick` and `slot_end` strobes.
- **Top:** the FSM, the 32-bit TX shift register and the 16-bit RX shift register.

## Test plan
- **Write, CLK_DIV=2:** write phy 0x10, reg 0x00, data 0x1140.
  - Expect the MDIO bit stream at MDC rising edges to be 32×1, 01, 01, 10000, 00000, 10, then 0x1140 MSB first.
  - Expect `mdio_oen` = 0 throughout.
  - Expect `rsp_valid` at t+257 with `rsp_rdata` = 0.
- **Read with PHY model:** read phy 0x01, reg 0x02; the PHY model drives TA = Z0 and data 0x0141.
  - Expect `mdio_oen` to rise at slot 46.
  - Expect `rsp_rdata` = 0x0141 and `rsp_err` = 0.
- **Read with no PHY:** `mdio_in` tied to 1.
  - Expect `rsp_rdata` = 0xFFFF and `rsp_err` = 1.
- **Back-to-back:** hold `cmd_valid` high for two commands.
  - Expect the second accept in the cycle after the first `rsp_valid`.
  - Expect MDC low for ≥1 cycle between frames, and exactly 64 MDC rising edges per frame.
- **Reset mid-frame:** assert `reset` in slot 40 of a write.
  - Expect `mdc` = 0 and `mdio_oen` = 1 at once, and no `rsp_valid`.
  - After release, a new read completes correctly.
- **Busy hold:** assert `cmd_valid` with different fields during a frame.
  - Expect `cmd_ready` = 0 and the in-flight frame bits unchanged.
  - Expect the held command accepted after DONE.
